// File: rtl/tb_run_pkg.sv
// tb_run_pkg: shared types, widths and helpers for the run controller.
//   tb_run_state_t  : run sequencer state encoding
//   tb_run_result_t : outcome of a RUN-phase exit check
//   resultOf()      : prioritised exit classification (done > timeout > stall)
package tb_run_pkg;

    localparam int unsigned COUNT_W = 64;   // CycleCount / RunCycles width
    localparam int unsigned IDLE_W  = 32;   // no-progress counter width
    localparam int unsigned TIMER_W = 32;   // phase timer width

    typedef enum logic [1:0] {
        RESET_HOLD,
        RUN,
        DRAIN,
        DONE
    } tb_run_state_t;

    typedef enum {
        RES_NONE,
        RES_PASS,
        RES_FAIL,
        RES_TIMEOUT,
        RES_STALL
    } tb_run_result_t;

    // Classify this RUN cycle; a DUT completion always wins over the watchdogs.
    function automatic tb_run_result_t resultOf(
        input logic done,
        input logic pass,
        input logic timeoutHit,
        input logic stallHit
    );
        if (done) begin
            return pass ? RES_PASS : RES_FAIL;
        end else if (timeoutHit) begin
            return RES_TIMEOUT;
        end else if (stallHit) begin
            return RES_STALL;
        end
        return RES_NONE;
    endfunction

endpackage

// File: rtl/tb_phase_timer.sv
// tb_phase_timer: loadable down-counter with a zero flag, shared by the
// RESET_HOLD and DRAIN phases.
// Ports:
//   clk        clock, posedge
//   sync_rst   synchronous active-high reset; loads RESET_VALUE
//   load       load loadValue this cycle (wins over enable)
//   loadValue  value to load
//   enable     decrement by one, saturating at zero
//   isZero_c   combinational: counter currently zero
module tb_phase_timer
    import tb_run_pkg::*;
#(
    parameter int unsigned WIDTH       = TIMER_W,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             enable,
    output logic             isZero_c
);

    logic [WIDTH-1:0] count;

    // Down-counter register.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            count <= WIDTH'(RESET_VALUE);
        end else if (load) begin
            count <= loadValue;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign isZero_c = (count == '0);

endmodule

// File: rtl/tb_run_controller.sv
// tb_run_controller: bench-side run sequencer. Holds the DUT in reset, runs it
// under a cycle-limit and a no-progress watchdog, drains, then latches a verdict.
// Optional feature macro: TB_RUN_FINISH_EN -- when defined, entering DONE prints
// one summary line and ends the simulation; Restart is then never honoured.
// Ports:
//   clk, sync_rst         clock / synchronous active-high reset
//   Restart               pulse; starts a new run from DONE
//   DUTDone, DUTPass      DUT completion and verdict, sampled in RUN
//   Heartbeat             DUT progress strobe, sampled in RUN
//   DUTReset              reset to the DUT (RESET_HOLD)
//   Running, Finished     state decodes for RUN / DONE
//   Passed, TimedOut, Stalled   latched, mutually exclusive verdict flags
//   CycleCount            free-running cycles since sync_rst
//   RunCycles             RUN cycles of the current/last run
module tb_run_controller
    import tb_run_pkg::*;
#(
    parameter int unsigned RESETCYCLES = 4,
    parameter int unsigned CYCLELIMIT  = 256,
    parameter int unsigned STALLLIMIT  = 64,
    parameter int unsigned DRAINCYCLES = 8
) (
    input  logic        clk,
    input  logic        sync_rst,
    input  logic        Restart,
    input  logic        DUTDone,
    input  logic        DUTPass,
    input  logic        Heartbeat,
    output logic        DUTReset,
    output logic        Running,
    output logic        Finished,
    output logic        Passed,
    output logic        TimedOut,
    output logic        Stalled,
    output logic [63:0] CycleCount,
    output logic [63:0] RunCycles
);

    // The sync_rst load covers the reset cycle itself, so a Restart loads one
    // less to give the same RESETCYCLES-cycle hold. DRAIN exits on zero, hence -1.
    localparam int unsigned RESTART_LOAD = (RESETCYCLES == 0) ? 0 : RESETCYCLES - 1;
    localparam int unsigned DRAIN_LOAD   = (DRAINCYCLES == 0) ? 0 : DRAINCYCLES - 1;
    localparam int unsigned TIMEOUT_AT   = (CYCLELIMIT == 0) ? 0 : CYCLELIMIT - 1;
    localparam int unsigned STALL_AT     = (STALLLIMIT == 0) ? 0 : STALLLIMIT - 1;

    tb_run_state_t  state;
    tb_run_state_t  stateNext;
    tb_run_result_t exitResult;

    logic [IDLE_W-1:0]  idleCount;
    logic [IDLE_W-1:0]  idleCountNext;
    logic [COUNT_W-1:0] runCyclesNext;
    logic               passedNext;
    logic               timedOutNext;
    logic               stalledNext;

    logic               timerLoad;
    logic [TIMER_W-1:0] timerLoadValue;
    logic               timerEnable;
    logic               timerZero;
    logic               timeoutHit;
    logic               stallHit;

    tb_phase_timer #(
        .WIDTH       (TIMER_W),
        .RESET_VALUE (RESETCYCLES)
    ) u_phase_timer (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .load      (timerLoad),
        .loadValue (timerLoadValue),
        .enable    (timerEnable),
        .isZero_c  (timerZero)
    );

    // Watchdog compares use the counts before this cycle's increment.
    assign timeoutHit = (CYCLELIMIT != 0) && (RunCycles == COUNT_W'(TIMEOUT_AT));
    assign stallHit   = (STALLLIMIT != 0) && !Heartbeat
                        && (idleCount == IDLE_W'(STALL_AT));

    // State register.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state <= RESET_HOLD;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, timer control and next values of the registered outputs.
    always_comb begin
        stateNext      = state;
        exitResult     = RES_NONE;
        timerLoad      = 1'b0;
        timerLoadValue = '0;
        timerEnable    = 1'b0;
        runCyclesNext  = RunCycles;
        idleCountNext  = idleCount;
        passedNext     = Passed;
        timedOutNext   = TimedOut;
        stalledNext    = Stalled;

        case (state)
            RESET_HOLD: begin
                if (timerZero) begin
                    stateNext = RUN;
                end else begin
                    timerEnable = 1'b1;
                end
            end
            RUN: begin
                runCyclesNext = RunCycles + COUNT_W'(1);
                idleCountNext = Heartbeat ? '0 : idleCount + IDLE_W'(1);
                exitResult    = resultOf(DUTDone, DUTPass, timeoutHit, stallHit);
                if (exitResult != RES_NONE) begin
                    passedNext   = (exitResult == RES_PASS);
                    timedOutNext = (exitResult == RES_TIMEOUT);
                    stalledNext  = (exitResult == RES_STALL);
                    if (DRAINCYCLES == 0) begin
                        stateNext = DONE;
                    end else begin
                        stateNext      = DRAIN;
                        timerLoad      = 1'b1;
                        timerLoadValue = TIMER_W'(DRAIN_LOAD);
                    end
                end
            end
            DRAIN: begin
                if (timerZero) begin
                    stateNext = DONE;
                end else begin
                    timerEnable = 1'b1;
                end
            end
            DONE: begin
`ifndef TB_RUN_FINISH_EN
                if (Restart) begin
                    stateNext      = RESET_HOLD;
                    timerLoad      = 1'b1;
                    timerLoadValue = TIMER_W'(RESTART_LOAD);
                    runCyclesNext  = '0;
                    idleCountNext  = '0;
                    passedNext     = 1'b0;
                    timedOutNext   = 1'b0;
                    stalledNext    = 1'b0;
                end
`endif
            end
            default: stateNext = RESET_HOLD;
        endcase
    end

    // Registered outputs and counters.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            DUTReset   <= 1'b1;
            Running    <= 1'b0;
            Finished   <= 1'b0;
            Passed     <= 1'b0;
            TimedOut   <= 1'b0;
            Stalled    <= 1'b0;
            CycleCount <= '0;
            RunCycles  <= '0;
            idleCount  <= '0;
        end else begin
            DUTReset   <= (stateNext == RESET_HOLD);
            Running    <= (stateNext == RUN);
            Finished   <= (stateNext == DONE);
            Passed     <= passedNext;
            TimedOut   <= timedOutNext;
            Stalled    <= stalledNext;
            CycleCount <= CycleCount + COUNT_W'(1);
            RunCycles  <= runCyclesNext;
            idleCount  <= idleCountNext;
        end
    end

`ifdef TB_RUN_FINISH_EN
    // Report the verdict once on entry to DONE and end the simulation.
    always_ff @(posedge clk) begin
        if (!sync_rst && (state != DONE) && (stateNext == DONE)) begin
            if (passedNext) begin
                $display("tb_run_controller: PASS RunCycles=%0d CycleCount=%0d",
                         runCyclesNext, CycleCount + COUNT_W'(1));
            end else if (timedOutNext) begin
                $display("tb_run_controller: TIMEOUT RunCycles=%0d CycleCount=%0d",
                         runCyclesNext, CycleCount + COUNT_W'(1));
            end else if (stalledNext) begin
                $display("tb_run_controller: STALL RunCycles=%0d CycleCount=%0d",
                         runCyclesNext, CycleCount + COUNT_W'(1));
            end else begin
                $display("tb_run_controller: FAIL RunCycles=%0d CycleCount=%0d",
                         runCyclesNext, CycleCount + COUNT_W'(1));
            end
            $finish;
        end
    end
`endif

endmodule
